// File: rtl/trace_event_monitor.sv
// trace_event_monitor: collects EXIT/REPORT/PUTC trace events from several cores into one event FIFO
//   clk             : clock, rising edge
//   rst_sys_n       : asynchronous active-low reset
//   enable          : per-core writeback valid
//   wb_pc/wb_insn/r3: per-core writeback PC, instruction word and GPR r3 (32 bits per core)
//   ev_valid/ev_ready, ev_core/ev_type/ev_data/ev_pc : head of the event FIFO
//   core_done       : per-core sticky EXIT flag; termination_all is their AND
//   dropped         : saturating count of events lost to pending-slot overflow
module trace_event_monitor #(
    parameter int CORES      = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_sys_n,
    input  logic [CORES-1:0]      enable,
    input  logic [32*CORES-1:0]   wb_pc,
    input  logic [32*CORES-1:0]   wb_insn,
    input  logic [32*CORES-1:0]   r3,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [3:0]            ev_core,
    output logic [1:0]            ev_type,
    output logic [31:0]           ev_data,
    output logic [31:0]           ev_pc,
    output logic [CORES-1:0]      core_done,
    output logic                  termination_all,
    output logic [CNT_WIDTH-1:0]  dropped
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = CNT_WIDTH + 5;
    localparam logic [31:0] EXIT   = 32'h15000001;
    localparam logic [31:0] REPORT = 32'h15000002;
    localparam logic [31:0] PUTC   = 32'h15000004;
    localparam logic [CNT_WIDTH-1:0] MAXC = '1;

    logic [CORES-1:0]     w_ev, w_exit, w_load, w_drop, w_gnt;
    logic [1:0]           w_type [CORES];
    logic [CORES-1:0]     r_slot_v, r_done;
    logic [1:0]           r_slot_type [CORES];
    logic [31:0]          r_slot_data [CORES];
    logic [31:0]          r_slot_pc [CORES];
    logic [3:0]           r_ptr, w_gnt_idx;
    logic [69:0]          w_gnt_ent;
    logic                 w_gnt_v, w_full, w_push, w_pop;
    logic [69:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr, r_rd;
    logic [AW:0]          r_cnt;
    logic [4:0]           w_ndrop;
    logic [DW-1:0]        w_dsum;
    logic [CNT_WIDTH-1:0] r_dropped, w_dnext;

    for (genvar i = 0; i < CORES; i++) begin : g_dec
        logic [31:0] w_insn;
        assign w_insn    = wb_insn[32*i +: 32];
        assign w_type[i] = w_insn == REPORT ? 2'd1 : w_insn == PUTC ? 2'd2 : 2'd0;
        assign w_exit[i] = w_insn == EXIT;
        assign w_ev[i]   = enable[i] && !r_done[i] && (w_exit[i] || w_insn == REPORT || w_insn == PUTC);
    end

    // A slot accepts a new event when empty or when its current entry leaves this cycle.
    assign w_load = w_ev & (~r_slot_v | w_gnt);
    assign w_drop = w_ev & ~w_load;

    // Round robin: the second pass (indices >= r_ptr) overrides the first, and the
    // descending scan leaves the lowest qualifying index, giving the first occupied
    // slot at or after r_ptr, wrapping round to the lowest one below it.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_ent = '0;
        for (int p = 0; p < 2; p++)
            for (int i = CORES - 1; i >= 0; i--)
                if (r_slot_v[i] && ((i >= int'(r_ptr)) == (p == 1))) begin
                    w_gnt     = '0;
                    w_gnt[i]  = 1'b1;
                    w_gnt_idx = 4'(i);
                    w_gnt_ent = {4'(i), r_slot_type[i], r_slot_data[i], r_slot_pc[i]};
                end
        if (w_full)
            w_gnt = '0;
    end

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < CORES; i++)
            w_ndrop = w_ndrop + 5'(w_drop[i]);
        w_dsum  = DW'(r_dropped) + DW'(w_ndrop);
        w_dnext = w_dsum > DW'(MAXC) ? MAXC : w_dsum[CNT_WIDTH-1:0];
    end

    assign w_gnt_v  = |w_gnt;
    assign w_full   = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_push   = w_gnt_v;
    assign w_pop    = ev_valid && ev_ready;
    assign ev_valid = r_cnt != '0;
    assign {ev_core, ev_type, ev_data, ev_pc} = ev_valid ? r_mem[r_rd] : '0;
    assign core_done       = r_done;
    assign termination_all = &r_done;
    assign dropped         = r_dropped;

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_slot_v  <= '0;
            r_done    <= '0;
            r_ptr     <= '0;
            r_dropped <= '0;
            r_cnt     <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
        end else begin
            r_slot_v  <= (r_slot_v & ~w_gnt) | w_ev;
            r_done    <= r_done | (w_ev & w_exit);
            r_dropped <= w_dnext;
            if (w_gnt_v)
                r_ptr <= w_gnt_idx == 4'(CORES - 1) ? 4'd0 : w_gnt_idx + 4'd1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
        end
    end

    // Payloads need no reset: they are only observed through valid flags.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CORES; i++)
            if (w_load[i]) begin
                r_slot_type[i] <= w_type[i];
                r_slot_data[i] <= r3[32*i +: 32];
                r_slot_pc[i]   <= wb_pc[32*i +: 32];
            end
        if (w_push)
            r_mem[r_wr] <= w_gnt_ent;
    end
endmodule

// File: tb/tb_trace_event_monitor.sv
// tb_trace_event_monitor: scoreboard bench for trace_event_monitor (4 cores, 2-entry FIFO, 2-bit drop counter)
module tb_trace_event_monitor;
    localparam int C = 4;
    localparam logic [31:0] EXIT   = 32'h15000001;
    localparam logic [31:0] REPORT = 32'h15000002;
    localparam logic [31:0] PUTC   = 32'h15000004;

    logic            clk = 1'b0;
    logic            rst_sys_n = 1'b0;
    logic            ev_ready = 1'b0;
    logic [C-1:0]    enable = '0;
    logic [32*C-1:0] wb_pc = '0;
    logic [32*C-1:0] wb_insn = '0;
    logic [32*C-1:0] r3 = '0;
    logic            ev_valid;
    logic [3:0]      ev_core;
    logic [1:0]      ev_type;
    logic [31:0]     ev_data;
    logic [31:0]     ev_pc;
    logic [C-1:0]    core_done;
    logic            termination_all;
    logic [1:0]      dropped;

    logic [69:0] q[$];
    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    trace_event_monitor #(.CORES(C), .FIFO_DEPTH(2), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst_sys_n(rst_sys_n), .enable(enable), .wb_pc(wb_pc),
        .wb_insn(wb_insn), .r3(r3), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_core(ev_core), .ev_type(ev_type), .ev_data(ev_data), .ev_pc(ev_pc),
        .core_done(core_done), .termination_all(termination_all), .dropped(dropped)
    );

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Every accepted event must be the next expected one; nothing may appear when none is expected.
    always @(negedge clk)
        if (rst_sys_n && ev_ready) begin
            if (q.size() == 0)
                chk("spurious", 70'(ev_valid), 70'(0));
            else if (ev_valid)
                chk("event", {ev_core, ev_type, ev_data, ev_pc}, q.pop_front());
        end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable  = '0;
        wb_insn = '0;
    endtask

    task automatic set_core(input int c, input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] d);
        enable[c]           = 1'b1;
        wb_insn[32*c +: 32] = insn;
        wb_pc[32*c +: 32]   = pc;
        r3[32*c +: 32]      = d;
    endtask

    task automatic expect_ev(input int c, input logic [1:0] t, input logic [31:0] pc, input logic [31:0] d);
        q.push_back({4'(c), t, d, pc});
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++)
            @(negedge clk);
        chk("drain", 70'(q.size()), 70'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 70'(ev_valid), 70'(0));
        chk({tag, "_head"}, {ev_core, ev_type, ev_data, ev_pc}, 70'(0));
        chk({tag, "_done"}, 70'(core_done), 70'(0));
        chk({tag, "_term"}, 70'(termination_all), 70'(0));
        chk({tag, "_drop"}, 70'(dropped), 70'(0));
    endtask

    // All cores REPORT at one edge; events must leave on four consecutive cycles starting at core 'first'.
    task automatic rr_burst(input int first);
        for (int c = 0; c < C; c++)
            set_core(c, REPORT, 32'h200 + 32'(4 * c), 32'h1000 + 32'(c));
        for (int k = 0; k < C; k++)
            expect_ev((first + k) % C, 2'd1, 32'h200 + 32'(4 * ((first + k) % C)), 32'h1000 + 32'((first + k) % C));
        step();
        idle();
        @(negedge clk) chk("rr_pre", 70'(ev_valid), 70'(0));
        repeat (C) @(negedge clk) chk("rr_burst", 70'(ev_valid), 70'(1));
        @(negedge clk) chk("rr_post", 70'(ev_valid), 70'(0));
        chk("rr_drop", 70'(dropped), 70'(0));
        step();
    endtask

    initial begin
        #1 chk_zero("rst");
        repeat (2) @(posedge clk);
        #3 rst_sys_n = 1'b1;
        step();
        ev_ready = 1'b1;

        // two-cycle latency, single-cycle presentation
        set_core(0, PUTC, 32'h100, 32'h41);
        expect_ev(0, 2'd2, 32'h100, 32'h41);
        step();
        idle();
        @(negedge clk) chk("lat1", 70'(ev_valid), 70'(0));
        @(negedge clk) chk("lat2", 70'(ev_valid), 70'(1));
        @(negedge clk) chk("lat3", 70'(ev_valid), 70'(0));
        step();

        // core 0 was granted last, so the search starts at core 1
        rr_burst(1);

        // overflow: FIFO 2 + slot 1, fourth event dropped
        ev_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_core(0, PUTC, 32'h300 + 32'(k), 32'h50 + 32'(k));
            step();
        end
        idle();
        for (int k = 0; k < 3; k++)
            expect_ev(0, 2'd2, 32'h300 + 32'(k), 32'h50 + 32'(k));
        @(negedge clk);
        chk("ovf_drop", 70'(dropped), 70'(1));
        chk("ovf_valid", 70'(ev_valid), 70'(1));
        repeat (3) step();
        @(negedge clk);
        chk("ovf_hold_data", 70'(ev_data), 70'(32'h50));
        chk("ovf_hold_pc", 70'(ev_pc), 70'(32'h300));
        ev_ready = 1'b1;
        drain(20);
        chk("ovf_drop_after", 70'(dropped), 70'(1));
        step();

        // saturation: three more drops push 1 past the 2-bit maximum
        ev_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_core(0, PUTC, 32'h400 + 32'(k), 32'h60 + 32'(k));
            step();
        end
        idle();
        @(negedge clk);
        chk("sat_drop", 70'(dropped), 70'(3));
        chk("pre_rst_valid", 70'(ev_valid), 70'(1));

        // asynchronous reset between edges with events queued
        step();
        #2 rst_sys_n = 1'b0;
        q.delete();
        #1 chk_zero("rst_pulse");
        #10 rst_sys_n = 1'b1;
        ev_ready = 1'b1;
        step();
        repeat (4) step();
        chk_zero("post_rst");

        // after reset the pointer starts at core 0
        rr_burst(0);

        // ignored words: unknown opcode, and EXIT with enable low
        for (int c = 0; c < C; c++)
            set_core(c, 32'h15000003, 32'h0, 32'h0);
        step();
        for (int c = 0; c < C; c++)
            set_core(c, EXIT, 32'h0, 32'h0);
        enable = '0;
        step();
        idle();
        repeat (4) step();
        chk("ign_done", 70'(core_done), 70'(0));

        // termination
        set_core(0, EXIT, 32'h500, 32'hA0);
        set_core(2, EXIT, 32'h508, 32'hA2);
        expect_ev(0, 2'd0, 32'h500, 32'hA0);
        expect_ev(2, 2'd0, 32'h508, 32'hA2);
        step();
        idle();
        chk("term_a_done", 70'(core_done), 70'(4'b0101));
        chk("term_a", 70'(termination_all), 70'(0));
        drain(20);
        step();
        set_core(1, EXIT, 32'h504, 32'hA1);
        expect_ev(1, 2'd0, 32'h504, 32'hA1);
        step();
        idle();
        chk("term_b_done", 70'(core_done), 70'(4'b0111));
        chk("term_b", 70'(termination_all), 70'(0));
        drain(20);
        step();
        set_core(3, EXIT, 32'h50C, 32'hA3);
        expect_ev(3, 2'd0, 32'h50C, 32'hA3);
        step();
        idle();
        chk("term_c_done", 70'(core_done), 70'(4'b1111));
        chk("term_c", 70'(termination_all), 70'(1));
        drain(20);
        step();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < C; c++)
                set_core(c, k == 1 ? EXIT : PUTC, 32'h600, 32'h77);
            step();
        end
        idle();
        repeat (6) step();
        chk("post_term_valid", 70'(ev_valid), 70'(0));
        chk("post_term_done", 70'(core_done), 70'(4'b1111));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
